scan_decoder: RTL and testbench
===============================

# scan_decoder

Registered, parametrised binary-to-one-hot decoder with a built-in scan sequencer. In manual mode it decodes an externally supplied index. In scan mode it steps through all outputs itself, holding each for a programmable dwell. It sits between control logic and multiplexed loads such as display digit strobes, LED columns and keypad row drives.

## Interface
- OUTPUTS, 4, number of one-hot outputs; 2..2**OUTPUTS_WIDTH, need not be a power of two
- OUTPUTS_WIDTH, 2, width of select/index
- DIV_WIDTH, 16, width of dwell divider
- BLANK_CYCLES, 2, all-off cycles between dwells; 1..255; used only with blanking compiled in
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces outputs off
- mode  input  1  0 = manual, 1 = scan
- select  input  OUTPUTS_WIDTH  manual-mode output index
- div  input  DIV_WIDTH  dwell length minus one, in clk cycles
- out  output  OUTPUTS  registered one-hot drive; all-zero when off
- index  output  OUTPUTS_WIDTH  index currently driven (or next to be driven)
- wrap  output  1  one-cycle pulse when scan index wraps OUTPUTS-1 -> 0

## Operation
- Reset (async, rst_n low):
  - state IDLE
  - out = 0, index = 0, wrap = 0
  - dwell and blank counters = 0
- States:
  - IDLE: out = 0.
  - DWELL: out = one-hot(index).
  - BLANK: out = 0. Exists only with blanking compiled in.
- IDLE -> DWELL on the first cycle en = 1.
- Any state -> IDLE on the cycle en = 0. index is retained and counters are cleared.
- Manual mode (mode = 0, en = 1):
  - index <= select every cycle.
  - out <= one-hot(select).
  - select >= OUTPUTS gives out = 0 and index = select.
  - The dwell counter is held at 0 and wrap stays 0.
- Scan mode (mode = 1, en = 1):
  - The dwell counter increments each DWELL cycle.
  - When counter >= div, the dwell ends: counter clears and index <= (index == OUTPUTS-1) ? 0 : index+1.
  - The comparison is >=, so lowering div mid-dwell ends the dwell on the next cycle and never rolls over.
- wrap asserts in the same cycle index is updated from OUTPUTS-1 to 0.
- Switching manual -> scan: scanning starts from the current index with a fresh dwell; there is no glitch and no skipped output.
- Switching scan -> manual: index follows select on the next edge. An in-progress BLANK is abandoned.
- If index >= OUTPUTS on entry to scan (left over from manual mode), the next advance goes to 0 and wrap pulses.
- div = 0: each output is held for 1 cycle, so one full scan takes OUTPUTS cycles without blanking.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Manual latency: 1 cycle from select to out/index.
- Enable latency: out goes one-hot 1 cycle after en rises and goes 0 1 cycle after en falls.
- Scan period per output: div+1 cycles of DWELL, plus BLANK_CYCLES of BLANK when compiled in.
- out never has more than one bit set on any cycle, including at mode switches and reset release.

## Configuration
- SCAN_DECODER_BLANK_EN defined:
  - Each scan-mode dwell end enters BLANK for BLANK_CYCLES cycles with out = 0.
  - index advances at BLANK entry, and wrap pulses at BLANK entry.
  - DWELL for the new index follows BLANK.
  - Manual mode never blanks.
- SCAN_DECODER_BLANK_EN undefined:
  - There is no BLANK state and no blank counter.
  - Dwell end moves directly to the next index's DWELL, giving back-to-back one-hot outputs.

## Structure
- Package scan_decoder_pkg holds:
  - state encoding constants: ST_IDLE, ST_DWELL, ST_BLANK
  - mode constants: MODE_MANUAL = 0, MODE_SCAN = 1
- Sub-module: the existing binary_decoder, with OUTPUTS/OUTPUTS_WIDTH passed through. It produces the combinational one-hot of the next index, which scan_decoder registers into out.
- The FSM, counters and wrap logic live in scan_decoder itself.

## Test plan
- Reset and enable: reset asserted mid-scan -> out = 0, index = 0, wrap = 0 immediately (asynchronously). Release with en = 0 -> out stays 0.
- Manual mode, OUTPUTS = 5, OUTPUTS_WIDTH = 3: drive select 0..7 -> out = 00001, 00010, 00100, 01000, 10000, then 0 for select 5..7, each 1 cycle after select.
- Scan mode, OUTPUTS = 5, div = 3, blanking off -> each out bit high for exactly 4 cycles in order 0..4. wrap pulses once every 20 cycles, coincident with index 4 -> 0.
- Scan mode with SCAN_DECODER_BLANK_EN, BLANK_CYCLES = 2, div = 1 -> each output follows the pattern 2 cycles high then 2 cycles all-zero. The period is 20 cycles for 5 outputs.
- Live div change: div 10 -> 2 when the dwell counter is at 6 -> dwell ends the next cycle and subsequent dwells are 3 cycles.
- Mode switch: manual with select = 3, then mode -> 1 with div = 0 -> out sequence 3, 4, 0 (wrap pulses), 1, and out is one-hot on every cycle.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared FSM state encoding and mode constants for scan_decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/binary_decoder.sv
// binary_decoder: combinational binary index to one-hot; indices >= OUTPUTS decode to all-zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: sel (binary index in), onehot (decoded vector out).
module binary_decoder #(
  parameter int OUTPUTS       = 4,
  parameter int OUTPUTS_WIDTH = 2
) (
  input  logic [OUTPUTS_WIDTH-1:0] sel,
  output logic [OUTPUTS-1:0]       onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      onehot[i] = (sel == OUTPUTS_WIDTH'(i));
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with a manual mode (decode select) and a self-stepping scan mode.
// Latency: 1 cycle from en/select to out/index; scan holds each output div+1 cycles (+BLANK_CYCLES blanking).
// Backpressure: none; out is free-running, en low forces all outputs off and parks the FSM in IDLE.
// Ports: clk, rst_n (async active-low), en, mode (0 manual / 1 scan), select, div (dwell-1),
//        out (one-hot drive), index (current/next index), wrap (pulse on index wrap to 0).
// Build option: define SCAN_DECODER_BLANK_EN to insert BLANK_CYCLES all-off cycles between scan dwells.
module scan_decoder #(
  parameter int OUTPUTS       = 4,
  parameter int OUTPUTS_WIDTH = 2,
  parameter int DIV_WIDTH     = 16,
  parameter int BLANK_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [OUTPUTS_WIDTH-1:0] select,
  input  logic [DIV_WIDTH-1:0]     div,
  output logic [OUTPUTS-1:0]       out,
  output logic [OUTPUTS_WIDTH-1:0] index,
  output logic                     wrap
);

  import scan_decoder_pkg::*;

  localparam logic [OUTPUTS_WIDTH-1:0] LAST_IDX = OUTPUTS_WIDTH'(OUTPUTS - 1);

  state_t                   state;
  logic [DIV_WIDTH-1:0]     dwell_cnt;
  logic                     dwell_end;
  logic [OUTPUTS_WIDTH-1:0] idx_adv;
  logic [OUTPUTS_WIDTH-1:0] idx_next;
  logic [OUTPUTS-1:0]       onehot_next;

`ifdef SCAN_DECODER_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
  logic [7:0] blank_cnt;
`endif

  // >= rather than == so a div lowered below the running count ends the dwell at once.
  assign dwell_end = (state == ST_DWELL) && (dwell_cnt >= div);

  // An out-of-range index left over from manual mode also advances to 0.
  assign idx_adv = (index >= LAST_IDX) ? '0 : index + 1'b1;

  // Index that will be registered this edge; the decoder works on it so out
  // and index always change together.
  always_comb begin
    idx_next = index;
    if (en) begin
      if (mode == MODE_MANUAL) begin
        idx_next = select;
      end else if (dwell_end) begin
        idx_next = idx_adv;
      end
    end
  end

  binary_decoder #(
    .OUTPUTS       (OUTPUTS),
    .OUTPUTS_WIDTH (OUTPUTS_WIDTH)
  ) u_binary_decoder (
    .sel    (idx_next),
    .onehot (onehot_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      index     <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      blank_cnt <= '0;
`endif
    end else if (!en) begin
      // index is deliberately kept so scanning resumes where it stopped.
      state     <= ST_IDLE;
      out       <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      blank_cnt <= '0;
`endif
    end else if (mode == MODE_MANUAL) begin
      // Parking in DWELL with a zero count makes a later switch to scan
      // continue the current output as a fresh dwell.
      state     <= ST_DWELL;
      index     <= idx_next;
      out       <= onehot_next;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      blank_cnt <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_DWELL: begin
          if (dwell_end) begin
            index     <= idx_next;
            wrap      <= (index >= LAST_IDX);
            dwell_cnt <= '0;
`ifdef SCAN_DECODER_BLANK_EN
            state     <= ST_BLANK;
            out       <= '0;
            blank_cnt <= '0;
`else
            out       <= onehot_next;
`endif
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            out       <= onehot_next;
          end
        end
`ifdef SCAN_DECODER_BLANK_EN
        ST_BLANK: begin
          // index already points at the next output; light it when blanking is done.
          if (blank_cnt >= BLANK_LAST) begin
            state     <= ST_DWELL;
            out       <= onehot_next;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= ST_DWELL;
          out       <= onehot_next;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed self-checking bench for scan_decoder (OUTPUTS=5, OUTPUTS_WIDTH=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] select;
  logic [15:0] div;
  logic [4:0] out;
  logic [2:0] index;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_decoder #(
    .OUTPUTS       (5),
    .OUTPUTS_WIDTH (3),
    .DIV_WIDTH     (16),
    .BLANK_CYCLES  (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .select (select),
    .div    (div),
    .out    (out),
    .index  (index),
    .wrap   (wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] man_exp [0:7];
  int sw_out  [0:5];
  int sw_idx  [0:5];
  int sw_wrap [0:5];

  initial begin
    int ei;
    int eo;
    int ew;
    int ph;

    man_exp[0] = 5'b00001; man_exp[1] = 5'b00010; man_exp[2] = 5'b00100;
    man_exp[3] = 5'b01000; man_exp[4] = 5'b10000; man_exp[5] = 5'b00000;
    man_exp[6] = 5'b00000; man_exp[7] = 5'b00000;
`ifdef SCAN_DECODER_BLANK_EN
    sw_out  = '{0, 0, 16, 0, 0, 1};
    sw_idx  = '{4, 4, 4, 0, 0, 0};
    sw_wrap = '{0, 0, 0, 1, 0, 0};
`else
    sw_out  = '{16, 1, 2, 4, 8, 16};
    sw_idx  = '{4, 0, 1, 2, 3, 4};
    sw_wrap = '{0, 1, 0, 0, 0, 0};
`endif

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; select = '0; div = '0;
    repeat (2) step();
    check_eq("rst_out", out, 0);
    check_eq("rst_index", index, 0);
    check_eq("rst_wrap", wrap, 0);

    rst_n = 1'b1;
    repeat (2) step();
    check_eq("en_low_out", out, 0);

    // Manual decode of every select value, including out-of-range ones.
    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      select = 3'(s);
      step();
      check_eq($sformatf("man_out%0d", s), out, man_exp[s]);
      check_eq($sformatf("man_idx%0d", s), index, s);
      check_eq($sformatf("man_wrap%0d", s), wrap, 0);
    end

    // Full scan from index 0; output 0 is already lit at k = 0.
    select = 3'd0;
    step();
`ifdef SCAN_DECODER_BLANK_EN
    div = 16'd1;
`else
    div = 16'd3;
`endif
    mode = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
`ifdef SCAN_DECODER_BLANK_EN
      ph = k % 4;
      ei = ((k + 2) / 4) % 5;
      eo = (ph < 2) ? (1 << ((k / 4) % 5)) : 0;
      ew = ((k + 2) % 20 == 0) ? 1 : 0;
`else
      ei = (k / 4) % 5;
      eo = 1 << ei;
      ew = (k % 20 == 0) ? 1 : 0;
`endif
      check_eq($sformatf("scan_out_k%0d", k), out, eo);
      check_eq($sformatf("scan_idx_k%0d", k), index, ei);
      check_eq($sformatf("scan_wrap_k%0d", k), wrap, ew);
    end

    // Live div change: 10 -> 2 with the dwell counter at 6.
    mode = 1'b0; select = 3'd2;
    step();
    mode = 1'b1; div = 16'd10;
    repeat (6) step();
    check_eq("div_pre_out", out, 5'b00100);
    check_eq("div_pre_idx", index, 2);
    div = 16'd2;
    for (int k = 7; k <= 18; k++) begin
      step();
`ifdef SCAN_DECODER_BLANK_EN
      ph = (k - 7) % 5;
      ei = (3 + (k - 7) / 5) % 5;
      eo = (ph < 2) ? 0 : (1 << ei);
`else
      ei = (3 + (k - 7) / 3) % 5;
      eo = 1 << ei;
`endif
      check_eq($sformatf("div_out_k%0d", k), out, eo);
      check_eq($sformatf("div_idx_k%0d", k), index, ei);
    end

    // Manual select 3 then scan with div 0.
    mode = 1'b0; select = 3'd3;
    step();
    check_eq("sw_pre_out", out, 5'b01000);
    mode = 1'b1; div = 16'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq($sformatf("sw_out_k%0d", k + 1), out, sw_out[k]);
      check_eq($sformatf("sw_idx_k%0d", k + 1), index, sw_idx[k]);
      check_eq($sformatf("sw_wrap_k%0d", k + 1), wrap, sw_wrap[k]);
      check_eq($sformatf("sw_onehot_k%0d", k + 1), ($countones(out) <= 1) ? 1 : 0, 1);
    end

    // Out-of-range index carried into scan goes to 0 with a wrap pulse.
    mode = 1'b0; select = 3'd6;
    step();
    check_eq("oor_pre_out", out, 0);
    check_eq("oor_pre_idx", index, 6);
    mode = 1'b1;
    step();
    check_eq("oor_idx", index, 0);
    check_eq("oor_wrap", wrap, 1);
`ifdef SCAN_DECODER_BLANK_EN
    check_eq("oor_out", out, 0);
`else
    check_eq("oor_out", out, 5'b00001);
`endif

    // Enable drop keeps index, rise relights after one cycle.
    mode = 1'b0; select = 3'd1;
    step();
    en = 1'b0;
    step();
    check_eq("dis_out", out, 0);
    check_eq("dis_idx", index, 1);
    check_eq("dis_wrap", wrap, 0);
    en = 1'b1;
    step();
    check_eq("ena_out", out, 5'b00010);

    // Asynchronous reset in the middle of a scan dwell.
    mode = 1'b1; div = 16'd3;
    repeat (3) step();
    check_eq("arst_pre_out", out, 5'b00010);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out", out, 0);
    check_eq("arst_idx", index, 0);
    check_eq("arst_wrap", wrap, 0);
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (2) step();
    check_eq("arst_rel_out", out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
